// File: rtl/computer_pkg.sv
// Shared constants and loader state encoding for the
// 4-bit computer and its program loader.
package computer_pkg;

  localparam int CPU_ADDR_W = 4;
  localparam int CPU_INS_W  = 8;
  localparam int CPU_DAT_W  = 4;

  typedef enum logic [2:0] {
    LD_IDLE    = 3'd0,
    LD_ACCEPT  = 3'd1,
    LD_SETUP   = 3'd2,
    LD_PULSE   = 3'd3,
    LD_RECOVER = 3'd4,
    LD_RELEASE = 3'd5,
    LD_RUN     = 3'd6
  } ld_state_e;

endpackage

// File: rtl/prog_loader_ctrl.sv
// Streams instruction/data words into the core's programming
// port while holding the core in reset, then releases it.
module prog_loader_ctrl
  import computer_pkg::*;
#(
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter int INS_W    = CPU_INS_W,
  parameter int DAT_W    = CPU_DAT_W,
  parameter int PULSE_W  = 1,
  parameter int RST_HOLD = 4
) (
  input  logic              osc_clock,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [INS_W-1:0]  ld_ins,
  input  logic [DAT_W-1:0]  ld_dat,
  input  logic              ld_last,
  output logic              prog_clk,
  output logic [ADDR_W-1:0] prog_add,
  output logic [INS_W-1:0]  prog_in,
  output logic [DAT_W-1:0]  prog_dat,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count
);

  localparam int TMAX  = (PULSE_W > RST_HOLD) ? PULSE_W : RST_HOLD;
  localparam int TMR_W = $clog2(TMAX + 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  ld_state_e         state_q;
  logic [TMR_W-1:0]  timer_q;
  logic              last_q;
  logic              prog_clk_q;
  logic [ADDR_W-1:0] prog_add_q;
  logic [INS_W-1:0]  prog_in_q;
  logic [DAT_W-1:0]  prog_dat_q;
  logic              cpu_reset_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W:0]   wr_count_q;

  always_ff @(posedge osc_clock or posedge reset) begin
    if (reset) begin
      state_q     <= LD_IDLE;
      timer_q     <= '0;
      last_q      <= 1'b0;
      prog_clk_q  <= 1'b0;
      prog_add_q  <= '0;
      prog_in_q   <= '0;
      prog_dat_q  <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        // start coinciding with done is dropped
        LD_IDLE, LD_RUN: begin
          if (start && !done_q) begin
            state_q     <= LD_ACCEPT;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            prog_add_q  <= '0;
            wr_count_q  <= '0;
          end
        end
        LD_ACCEPT: begin
          if (ld_valid) begin
            prog_in_q  <= ld_ins;
            prog_dat_q <= ld_dat;
            last_q     <= ld_last;
            state_q    <= LD_SETUP;
          end
        end
        LD_SETUP: begin
          prog_clk_q <= 1'b1;
          timer_q    <= TMR_W'(PULSE_W - 1);
          state_q    <= LD_PULSE;
        end
        LD_PULSE: begin
          if (timer_q == '0) begin
            prog_clk_q <= 1'b0;
            state_q    <= LD_RECOVER;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        LD_RECOVER: begin
          wr_count_q <= wr_count_q + (ADDR_W + 1)'(1);
          if (last_q || prog_add_q == ADDR_MAX) begin
            timer_q <= TMR_W'(RST_HOLD);
            state_q <= LD_RELEASE;
          end else begin
            prog_add_q <= prog_add_q + ADDR_W'(1);
            state_q    <= LD_ACCEPT;
          end
        end
        // RST_HOLD cycles spent here before the core is released
        LD_RELEASE: begin
          if (timer_q <= TMR_W'(1)) begin
            state_q     <= LD_RUN;
            cpu_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        default: state_q <= LD_IDLE;
      endcase
    end
  end

  assign ld_ready  = (state_q == LD_ACCEPT);
  assign prog_clk  = prog_clk_q;
  assign prog_add  = prog_add_q;
  assign prog_in   = prog_in_q;
  assign prog_dat  = prog_dat_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Directed + randomized bench for prog_loader_ctrl against a
// transaction-level model of the expected memory writes.
module tb_prog_loader_ctrl;

  localparam int PW = 2;
  localparam int RH = 4;

  logic       osc_clock = 1'b0;
  logic       reset;
  logic       start;
  logic       ld_valid;
  logic       ld_ready;
  logic [7:0] ld_ins;
  logic [3:0] ld_dat;
  logic       ld_last;
  logic       prog_clk;
  logic [3:0] prog_add;
  logic [7:0] prog_in;
  logic [3:0] prog_dat;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic [4:0] wr_count;

  prog_loader_ctrl #(
    .ADDR_W(4), .INS_W(8), .DAT_W(4),
    .PULSE_W(PW), .RST_HOLD(RH)
  ) dut (
    .osc_clock(osc_clock), .reset(reset), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_ins(ld_ins), .ld_dat(ld_dat), .ld_last(ld_last),
    .prog_clk(prog_clk), .prog_add(prog_add),
    .prog_in(prog_in), .prog_dat(prog_dat),
    .cpu_reset(cpu_reset), .busy(busy), .done(done),
    .wr_count(wr_count)
  );

  always #5 osc_clock = ~osc_clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int hi_cnt = 0;
  logic pclk_prev = 1'b0;
  logic [15:0] exp_q[$];
  logic [7:0] w_ins[16];
  logic [3:0] w_dat[16];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock; samples on the falling edge and tracks strobes
  task automatic tick();
    logic [15:0] e;
    @(posedge osc_clock);
    @(negedge osc_clock);
    cyc++;
    if (prog_clk && !pclk_prev) begin
      hi_cnt = 1;
      chk("wr_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_add_ins_dat", {prog_add, prog_in, prog_dat}, e);
      end
    end else if (prog_clk) begin
      hi_cnt++;
    end else if (pclk_prev) begin
      chk("pulse_width", hi_cnt, PW);
      fall_cyc = cyc;
    end
    pclk_prev = prog_clk;
  endtask

  task automatic send_word(input logic [7:0] ins,
                           input logic [3:0] dat, input bit last);
    bit hs = 0;
    int gap = $urandom_range(0, 3);
    repeat (gap) begin
      ld_valid = 1'b0;
      ld_ins   = 8'($urandom);
      ld_dat   = 4'($urandom);
      ld_last  = 1'($urandom);
      tick();
    end
    ld_valid = 1'b1;
    ld_ins   = ins;
    ld_dat   = dat;
    ld_last  = last;
    for (int w = 0; w < 64 && !hs; w++) begin
      hs = ld_ready;
      tick();
    end
    chk("accept_seen", 32'(hs), 1);
    ld_valid = 1'b0;
    ld_ins   = 8'($urandom);
    ld_dat   = 4'($urandom);
    ld_last  = 1'($urandom);
  endtask

  task automatic session(input int n, input bit use_last,
                         input bit do_start, input bit hold_start);
    if (do_start) begin
      start = 1'b1;
      tick();
      chk("busy_on_start", 32'(busy), 1);
      chk("rst_on_start", 32'(cpu_reset), 1);
      chk("wrc_cleared", 32'(wr_count), 0);
    end
    start = hold_start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({4'(i), w_ins[i], w_dat[i]});
      send_word(w_ins[i], w_dat[i], use_last && (i == n - 1));
    end
    start = 1'b0;
  endtask

  task automatic wait_release(input int n, input bit restart);
    bit rdy_seen = 0;
    bit fell = 0;
    for (int w = 0; w < 200 && !fell; w++) begin
      tick();
      if (ld_ready) rdy_seen = 1;
      if (!cpu_reset) fell = 1;
    end
    chk("release_seen", 32'(fell), 1);
    chk("rst_hold", cyc - fall_cyc, RH + 1);
    chk("done_pulse", 32'(done), 1);
    chk("wr_count", 32'(wr_count), n);
    chk("add_held", 32'(prog_add), n - 1);
    chk("dat_held", 32'(prog_dat), w_dat[n-1]);
    chk("no_ready_tail", 32'(rdy_seen), 0);
    chk("all_written", exp_q.size(), 0);
    chk("busy_in_run", 32'(busy), 0);
    if (restart) begin
      start = 1'b1;
      tick();
      chk("start_at_done_ign", 32'(busy), 0);
      chk("done_one_cycle", 32'(done), 0);
      tick();
      chk("restart_busy", 32'(busy), 1);
      chk("restart_rst", 32'(cpu_reset), 1);
      chk("restart_add", 32'(prog_add), 0);
      chk("restart_wrc", 32'(wr_count), 0);
      chk("restart_ready", 32'(ld_ready), 1);
      start = 1'b0;
    end else begin
      tick();
      chk("done_one_cycle", 32'(done), 0);
      chk("core_running", 32'(cpu_reset), 0);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      w_ins[i] = 8'($urandom);
      w_dat[i] = 4'($urandom);
    end
  endtask

  initial begin
    int n;
    bit done_seen;
    reset = 1'b1;
    start = 1'b0;
    ld_valid = 1'b0;
    ld_ins = '0;
    ld_dat = '0;
    ld_last = 1'b0;
    tick();
    tick();
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_prog_clk", 32'(prog_clk), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(ld_ready), 0);
    chk("rst_wrc", 32'(wr_count), 0);
    chk("rst_add", 32'(prog_add), 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ld_valid = 1'($urandom);
      tick();
      chk("idle_cpu_reset", 32'(cpu_reset), 1);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_prog_clk", 32'(prog_clk), 0);
    end
    ld_valid = 1'b0;

    // three-word program, last flagged on the third
    w_ins[0] = 8'h73; w_dat[0] = 4'd5;
    w_ins[1] = 8'h40; w_dat[1] = 4'd6;
    w_ins[2] = 8'hF0; w_dat[2] = 4'd7;
    session(3, 1, 1, 0);
    wait_release(3, 0);

    // full memory, no last: session ends itself after addr 15
    fill_random();
    session(16, 0, 1, 0);
    wait_release(16, 0);

    for (int k = 0; k < 3; k++) begin
      fill_random();
      n = $urandom_range(1, 16);
      session(n, 1, 1, 0);
      wait_release(n, 0);
    end

    // start held through a session, then at done, then after
    fill_random();
    session(4, 1, 1, 1);
    wait_release(4, 1);
    exp_q.push_back({4'd0, w_ins[0], w_dat[0]});
    exp_q.push_back({4'd1, w_ins[1], w_dat[1]});
    send_word(w_ins[0], w_dat[0], 0);
    send_word(w_ins[1], w_dat[1], 1);
    wait_release(2, 0);

    // reset during the strobe of the second word
    fill_random();
    session(2, 0, 1, 0);
    for (int w = 0; w < 8 && !prog_clk; w++) tick();
    chk("pulse2_seen", 32'(prog_clk), 1);
    chk("pulse2_written", exp_q.size(), 0);
    reset = 1'b1;
    #1;
    chk("arst_prog_clk", 32'(prog_clk), 0);
    chk("arst_cpu_reset", 32'(cpu_reset), 1);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ready", 32'(ld_ready), 0);
    chk("arst_done", 32'(done), 0);
    pclk_prev = 1'b0;
    hi_cnt = 0;
    exp_q.delete();
    @(negedge osc_clock);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) done_seen = 1;
    end
    chk("arst_no_done", 32'(done_seen), 0);
    chk("arst_held", 32'(cpu_reset), 1);

    fill_random();
    session(2, 1, 1, 0);
    wait_release(2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
